// File: rtl/dds_step_controller.sv
// DDS phase-increment tuning controller: debounced front-panel keys queue step
// requests that are applied one at a time and handed to the accumulator via req/ack.
//
// state   | meaning
// INIT    | after reset, publish STEP_DEFAULT
// IDLE    | waiting for a pending key request
// CALC    | apply highest-priority pending request (1 cycle)
// PUBLISH | upd_req high, step held until upd_ack
module dds_step_controller #(
  parameter logic [31:0] STEP_DEFAULT    = 32'd171798,
  parameter logic [31:0] COARSE_DELTA    = 32'd858993,
  parameter logic [31:0] MICRO_DELTA     = 32'd85899,
  parameter logic [31:0] NANO_DELTA      = 32'd85,
  parameter logic [31:0] STEP_MIN        = 32'd85,
  parameter logic [31:0] STEP_MAX        = 32'h7FFF_FFFF,
  parameter int          DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_default_n,
  input  logic        key_add_n,
  input  logic        key_sub_n,
  input  logic        key_micro_add_n,
  input  logic        key_micro_sub_n,
  input  logic        key_nano_add_n,
  input  logic        key_nano_sub_n,
  output logic [31:0] step,
  output logic        upd_req,
  input  logic        upd_ack,
  output logic        busy
);

  localparam int NKEY = 7;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [NKEY-1:0] ONE_HOT0 = NKEY'(1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CALC, S_PUBLISH} state_t;

  state_t            state_q, state_d;
  logic [NKEY-1:0]   keys_n, sync1, sync2, deb, flip, fall;
  logic [NKEY-1:0]   pend_q, pend_d, sel_oh, clr;
  logic [CW-1:0]     cnt [NKEY];
  logic [31:0]       step_q, step_d, delta, cand;
  logic [32:0]       sum, diff;
  logic              op_add;

  // bit index doubles as priority: bit 0 is serviced first
  assign keys_n = {key_nano_sub_n, key_nano_add_n, key_micro_sub_n, key_micro_add_n,
                   key_sub_n, key_add_n, key_default_n};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
    end else begin
      sync1 <= keys_n;
      sync2 <= sync1;
      deb   <= deb ^ flip;
    end
  end

  // down-counter reloads on any sample matching the debounced level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NKEY; i++) cnt[i] <= CNT_LOAD;
    end else begin
      for (int i = 0; i < NKEY; i++) begin
        if (sync2[i] == deb[i] || cnt[i] == '0) cnt[i] <= CNT_LOAD;
        else                                    cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NKEY; i++) flip[i] = (sync2[i] != deb[i]) && (cnt[i] == '0);
  end

  assign fall   = flip & deb;
  assign sel_oh = pend_q & (~pend_q + ONE_HOT0);
  assign op_add = |(sel_oh & 7'b0101010);
  assign delta  = (sel_oh[1] | sel_oh[2]) ? COARSE_DELTA :
                  (sel_oh[3] | sel_oh[4]) ? MICRO_DELTA  : NANO_DELTA;
  assign sum    = {1'b0, step_q} + {1'b0, delta};
  assign diff   = {1'b0, step_q} - {1'b0, delta};

  always_comb begin
    cand = step_q;
    if (sel_oh[0])   cand = STEP_DEFAULT;
    else if (op_add) cand = (sum > {1'b0, STEP_MAX}) ? STEP_MAX : sum[31:0];
    else             cand = (diff[32] || diff[31:0] < STEP_MIN) ? STEP_MIN : diff[31:0];
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    clr     = '0;
    case (state_q)
      S_INIT:    state_d = S_PUBLISH;
      S_IDLE:    if (|pend_q) state_d = S_CALC;
      S_CALC: begin
        clr = sel_oh;
        if (cand != step_q) begin
          step_d  = cand;
          state_d = S_PUBLISH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PUBLISH: if (upd_ack) state_d = S_IDLE;
      default:   state_d = S_INIT;
    endcase
    pend_d = (pend_q & ~clr) | fall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      step_q  <= STEP_DEFAULT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pend_q  <= pend_d;
    end
  end

  assign step    = step_q;
  assign upd_req = (state_q == S_PUBLISH);
  assign busy    = (state_q != S_IDLE) || (|pend_q);

endmodule

// File: tb/tb_dds_step_controller.sv
// Bench for dds_step_controller: cycle-level behavioural model compared every cycle,
// plus directed scenarios pinned with hand-computed step values.
module tb_dds_step_controller;

  localparam int     D    = 4;
  localparam longint SDEF = 171798;
  localparam longint CO   = 858993;
  localparam longint MI   = 85899;
  localparam longint NA   = 85;
  localparam longint SMIN = 85;
  localparam longint SMAX = 64'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  keys_n = '1;
  logic        upd_ack = 1'b0;
  logic [31:0] step;
  logic        upd_req, busy;
  int          ack_mode = 0;

  dds_step_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clk             (clk),
    .reset           (reset),
    .key_default_n   (keys_n[0]),
    .key_add_n       (keys_n[1]),
    .key_sub_n       (keys_n[2]),
    .key_micro_add_n (keys_n[3]),
    .key_micro_sub_n (keys_n[4]),
    .key_nano_add_n  (keys_n[5]),
    .key_nano_sub_n  (keys_n[6]),
    .step            (step),
    .upd_req         (upd_req),
    .upd_ack         (upd_ack),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 init, 1 idle, 2 calc, 3 publish
  int          m_ph = 0;
  logic [6:0]  m_pend = '0;
  longint      m_step = SDEF;
  logic [6:0]  m_d1 = '1, m_d2 = '1, m_lvl = '1;
  logic [D-1:0] m_hist [7];

  function automatic longint apply_key(input int k, input longint s);
    longint d;
    if (k == 0) return SDEF;
    d = (k <= 2) ? CO : (k <= 4) ? MI : NA;
    if (k % 2 == 1) return (s + d > SMAX) ? SMAX : s + d;
    return (s - d < SMIN) ? SMIN : s - d;
  endfunction

  always @(posedge clk) begin : model
    logic [6:0] falls, clr;
    int         nph, sel;
    longint     nv;
    if (reset) begin
      m_ph = 0; m_pend = '0; m_step = SDEF;
      m_d1 = '1; m_d2 = '1; m_lvl = '1;
      for (int k = 0; k < 7; k++) m_hist[k] = '1;
    end else begin
      falls = '0; clr = '0; nph = m_ph; sel = 0;
      for (int k = 0; k < 7; k++) begin
        m_hist[k] = {m_hist[k][D-2:0], m_d2[k]};
        if (m_hist[k] == {D{~m_lvl[k]}}) begin
          if (m_lvl[k]) falls[k] = 1'b1;
          m_lvl[k] = ~m_lvl[k];
        end
      end
      m_d2 = m_d1;
      m_d1 = keys_n;
      case (m_ph)
        0: nph = 3;
        1: if (m_pend != 0) nph = 2;
        2: begin
          for (int k = 6; k >= 0; k--) if (m_pend[k]) sel = k;
          clr[sel] = 1'b1;
          nv = apply_key(sel, m_step);
          if (nv != m_step) begin m_step = nv; nph = 3; end
          else nph = 1;
        end
        default: if (upd_ack) nph = 1;
      endcase
      m_pend = (m_pend & ~clr) | falls;
      m_ph   = nph;
    end
  end

  // ---------------- per-cycle compare and publish log ----------------
  logic [31:0] pub_q[$];
  logic        req_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    chk("step", step, m_step[31:0]);
    chk("upd_req", 32'(upd_req), 32'(m_ph == 3));
    chk("busy", 32'(busy), 32'((m_ph != 1) || (m_pend != 0)));
    if (upd_req && !req_prev) pub_q.push_back(step);
    req_prev = upd_req;
  end

  // accumulator: acks one cycle after req; random ack noise outside publish
  initial begin
    forever begin
      @(negedge clk);
      if (upd_req)
        upd_ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? 1'($urandom % 2) : 1'b0;
      else
        upd_ack = ($urandom % 4 == 0);
    end
  end

  function automatic logic [31:0] pub_at(input int i);
    if (i >= 0 && i < pub_q.size()) return pub_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic press(input int k, input int lo, input int hi);
    keys_n[k] = 1'b0;
    repeat (lo) @(negedge clk);
    keys_n[k] = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  int base;
  logic [6:0] mask;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_step", step, 32'd171798);
    chk("rst_req", 32'(upd_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("init_req", 32'(upd_req), 32'd1);
    chk("init_step", step, 32'd171798);
    repeat (3) @(negedge clk);
    chk("init_busy_low", 32'(busy), 32'd0);

    // long add press with a short release glitch: one request only
    base = pub_q.size();
    keys_n[1] = 1'b0; repeat (20) @(negedge clk);
    keys_n[1] = 1'b1; repeat (3) @(negedge clk);
    keys_n[1] = 1'b0; repeat (10) @(negedge clk);
    keys_n[1] = 1'b1; repeat (10) @(negedge clk);
    wait_idle();
    chk("glitch_cnt", 32'(pub_q.size() - base), 32'd1);
    chk("glitch_step", pub_at(base), 32'd1030791);

    // micro_add and nano_sub together: priority order
    press(0, 6, 6); wait_idle();
    base = pub_q.size();
    keys_n[3] = 1'b0; keys_n[6] = 1'b0;
    repeat (6) @(negedge clk);
    keys_n = '1;
    repeat (6) @(negedge clk);
    wait_idle();
    chk("dual_cnt", 32'(pub_q.size() - base), 32'd2);
    chk("dual_first", pub_at(base), 32'd257697);
    chk("dual_second", pub_at(base + 1), 32'd257612);

    // micro_sub down to the floor
    press(0, 6, 6); wait_idle();
    base = pub_q.size();
    for (int i = 0; i < 3; i++) press(4, 6, 6);
    wait_idle();
    chk("msub_cnt", 32'(pub_q.size() - base), 32'd2);
    chk("msub_first", pub_at(base), 32'd85899);
    chk("msub_clamp", pub_at(base + 1), 32'd85);
    chk("msub_hold", step, 32'd85);

    // climb to the ceiling with coarse adds
    press(0, 6, 6); wait_idle();
    base = pub_q.size();
    for (int i = 0; i < 2500; i++) press(1, $urandom_range(5, 8), $urandom_range(5, 8));
    wait_idle();
    chk("max_cnt", 32'(pub_q.size() - base), 32'd2500);
    chk("max_last", pub_at(pub_q.size() - 1), 32'h7FFF_FFFF);
    chk("max_step", step, 32'h7FFF_FFFF);
    base = pub_q.size();
    press(1, 6, 6); wait_idle();
    chk("max_nopub", 32'(pub_q.size() - base), 32'd0);
    press(0, 6, 6); wait_idle();
    chk("max_default", pub_at(pub_q.size() - 1), 32'd171798);

    // stalled handshake with a queued add
    ack_mode = 2;
    base = pub_q.size();
    press(1, 6, 6);
    press(1, 6, 6);
    repeat (5) @(negedge clk);
    chk("stall_req", 32'(upd_req), 32'd1);
    chk("stall_step", step, 32'd1030791);
    chk("stall_busy", 32'(busy), 32'd1);
    ack_mode = 0;
    wait_idle();
    chk("stall_cnt", 32'(pub_q.size() - base), 32'd2);
    chk("stall_second", pub_at(base + 1), 32'd1889784);

    // reset in the middle of a publish
    ack_mode = 2;
    press(2, 6, 6);
    repeat (2) @(negedge clk);
    chk("pre_rst_req", 32'(upd_req), 32'd1);
    chk("pre_rst_step", step, 32'd1030791);
    reset = 1'b1;
    #1;
    chk("midrst_req", 32'(upd_req), 32'd0);
    chk("midrst_step", step, 32'd171798);
    ack_mode = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rerst_req", 32'(upd_req), 32'd1);
    chk("rerst_step", step, 32'd171798);
    wait_idle();

    // random key patterns including sub-debounce glitches
    for (int it = 0; it < 80; it++) begin
      ack_mode = int'($urandom % 2);
      mask = 7'($urandom_range(1, 127));
      keys_n = ~mask;
      repeat ($urandom_range(1, 9)) @(negedge clk);
      keys_n = '1;
      repeat ($urandom_range(1, 9)) @(negedge clk);
    end
    ack_mode = 0;
    repeat (12) @(negedge clk);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_step_controller.md
# dds_step_controller

Synchronous tuning controller for the DDS phase-increment word. It synchronises and debounces seven active-low front-panel keys, queues one pending request per key, and applies them one at a time in fixed priority with saturating arithmetic. Each new step word is delivered to the phase-accumulator core through a req/ack handshake. It sits between the board keys and the DDS accumulator; the accumulator loads its increment only when it acknowledges a request.

## Interface
Parameters:
- STEP_DEFAULT, 32'd171798: step after reset and after a default-key press
- COARSE_DELTA, 32'd858993: coarse add/sub amount
- MICRO_DELTA, 32'd85899: micro add/sub amount
- NANO_DELTA, 32'd85: nano add/sub amount
- STEP_MIN, 32'd85: lower saturation bound
- STEP_MAX, 32'h7FFF_FFFF: upper saturation bound (Nyquist)
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples required to accept a key level; minimum 2

Ports:
- clk, input, 1: single system clock
- reset, input, 1: asynchronous, active-high
- key_default_n, input, 1: async key, active-low; restore STEP_DEFAULT
- key_add_n, input, 1: async key, active-low; coarse add
- key_sub_n, input, 1: async key, active-low; coarse subtract
- key_micro_add_n, input, 1: async key, active-low; micro add
- key_micro_sub_n, input, 1: async key, active-low; micro subtract
- key_nano_add_n, input, 1: async key, active-low; nano add
- key_nano_sub_n, input, 1: async key, active-low; nano subtract
- step, output, 32: current step word; changes only in CALC
- upd_req, output, 1: step is valid and must be loaded by the accumulator
- upd_ack, input, 1: accumulator has loaded step
- busy, output, 1: high whenever state ≠ IDLE or any pending bit is set

## Operation
- Input path, per key:
  - 2-FF synchroniser, then debounce counter.
  - Debounced level flips only after DEBOUNCE_CYCLES consecutive samples that differ from it; any matching sample resets the counter.
  - Debounced high→low transition sets that key's pending bit. A held key generates exactly one request (no auto-repeat).
  - A press while the pending bit is already set is merged (lost, not counted).
- Priority, highest first: default, add, sub, micro_add, micro_sub, nano_add, nano_sub.
- FSM states: INIT, IDLE, CALC, PUBLISH.
  - INIT: entered on reset; goes to PUBLISH next cycle, so STEP_DEFAULT is loaded into the accumulator.
  - IDLE: if any pending bit is set, go to CALC.
  - CALC (1 cycle):
    - Select the highest-priority pending bit and clear it.
    - Compute the candidate: default → STEP_DEFAULT; add → min(step+Δ, STEP_MAX); sub → max(step−Δ, STEP_MIN).
    - Arithmetic is 33-bit, so no wrap-around; saturation is evaluated before the store.
    - If candidate ≠ step: store it in step and go to PUBLISH. Otherwise stay on step and go to IDLE; no publish.
  - PUBLISH: upd_req=1 with step held stable. On the cycle upd_ack is sampled high, drop upd_req and go to IDLE.
- Pending bits keep setting in every state; they are serviced in later CALC cycles.
- A pending bit set on the same cycle CALC clears a different bit is kept.
- Reset mid-operation:
  - Outputs go to reset values immediately.
  - Pending bits, debounce counters and synchronisers clear; debounced levels reset to 1 (released).
  - Any outstanding handshake is abandoned.

## Timing
- Reset values: step=STEP_DEFAULT, upd_req=0, busy=1 (INIT), state=INIT.
- Publish after reset: upd_req rises at the first clk edge after reset deasserts.
- Key-to-pending latency: 2 (sync) + DEBOUNCE_CYCLES cycles after the key input goes low.
- Pending to upd_req: IDLE→CALC→PUBLISH, so upd_req is high 2 cycles after the pending bit is set (state IDLE).
- Handshake:
  - upd_ack may be held high; upd_req drops the cycle after ack is sampled.
  - The next upd_req can assert no earlier than 3 cycles later.
  - upd_ack outside PUBLISH is ignored.
- Throughput: at most one step update per 3 cycles plus ack wait.

## Test plan
Bench uses DEBOUNCE_CYCLES=4; accumulator model acks 1 cycle after req.
- Reset release → upd_req pulse with step=171798; busy falls after ack.
- key_add_n low for 20 cycles, then 3-cycle glitch high, then release → exactly one update, step=1030791; glitch produces no second request.
- key_nano_sub_n and key_micro_add_n pressed on the same cycle → two publishes, in order 257697 then 257612.
- From step=171798, press micro_sub 3 times → 85899, then 85 (clamped to STEP_MIN), then no publish (unchanged, step stays 85).
- Preload near STEP_MAX via repeated add presses; final add → step=32'h7FFF_FFFF, never wraps. Then default key → 171798.
- Hold upd_ack low during PUBLISH while pressing add → step and upd_req stay stable; add serviced after ack. Assert reset mid-PUBLISH → upd_req=0 and step=171798 immediately.
